dct_streamer: RTL and testbench

DCT_STREAMER -- requirements
Module: dct_streamer

---
 rtl/dct_pkg.sv | 19 +
 rtl/dct_streamer.sv | 186 ++++++++++++++++++
 tb/tb_dct_streamer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: definitions shared by the DCT streamer and the DCT peripheral.
//   DCT_ADDR_*       : peripheral register map (8-bit word addresses)
//   dct_strm_state_t : streamer FSM state encoding
package dct_pkg;

  localparam logic [7:0] DCT_ADDR_START = 8'd0;  // write: transform length, starts a transform
  localparam logic [7:0] DCT_ADDR_DATA  = 8'd1;  // write: next input sample
  localparam logic [7:0] DCT_ADDR_SETQ  = 8'd2;  // write: Q-format integer-bit count

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETQ    = 3'd1,
    SETSIZE = 3'd2,
    LOAD    = 3'd3,
    READ    = 3'd4,
    FIN     = 3'd5
  } dct_strm_state_t;

endpackage

// File: rtl/dct_streamer.sv
// dct_streamer: streams samples into a memory-mapped DCT peripheral and
// streams the resulting coefficients back out.
//
// A transform is: write Q format, write length N, write N samples, then read
// N coefficients (addresses 0..N-1). Data passes through bit-exact.
//
// Ports
//   clk, reset         : clock, asynchronous active-high reset
//   start, cfg_size,   : begin a transform of length cfg_size with Q-format
//   cfg_qm             :   cfg_qm (sampled only while idle)
//   in_valid/in_ready/ : sample input stream
//   in_data            :
//   out_valid/out_ready: coefficient output stream, out_last marks coeff N-1
//   out_data/out_last  :
//   busy               : high whenever not idle
//   err                : sticky bad-length flag, cleared by the next accepted start
//   avm_*              : master into the DCT peripheral; avm_done low stalls a read
//   dbg_state          : current FSM state
//
// Handshakes: a transfer occurs on a rising edge where valid && ready.
// A valid source holds its data stable until the transfer; ready may be
// asserted independently of valid. On the bus, a write completes in the cycle
// it is issued; a read is held (address and avm_read) until avm_done=1.
module dct_streamer
  import dct_pkg::*;
#(
  parameter int MAX_SIZE = 256,
  parameter int NBITS    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       cfg_size,
  input  logic [NBITS-1:0] cfg_qm,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err,
  output logic [7:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [NBITS-1:0] avm_writedata,
  input  logic [NBITS-1:0] avm_readdata,
  input  logic             avm_done,
  output dct_strm_state_t  dbg_state
);

  localparam logic [9:0] MAX_SZ = 10'(MAX_SIZE);

  dct_strm_state_t  state_q, state_d;
  logic [8:0]       size_q, size_d;
  logic [NBITS-1:0] qm_q, qm_d;
  logic [8:0]       count_q, count_d;
  logic [8:0]       k_q, k_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [NBITS-1:0] out_data_q, out_data_d;
  logic             err_q, err_d;
  logic             size_ok;

  assign size_ok = (cfg_size >= 9'd2) && ({1'b0, cfg_size} <= MAX_SZ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= '0;
      qm_q        <= '0;
      count_q     <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      qm_q        <= qm_d;
      count_q     <= count_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    qm_d          = qm_q;
    count_d       = count_q;
    k_d           = k_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_data_d    = out_data_q;
    err_d         = err_q;
    in_ready      = 1'b0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            size_d  = cfg_size;
            qm_d    = cfg_qm;
            err_d   = 1'b0;
            count_d = '0;
            k_d     = '0;
            state_d = SETQ;
          end else begin
            // Rejected length: flag it and stay idle without touching the bus.
            err_d = 1'b1;
          end
        end
      end

      SETQ: begin
        avm_write     = 1'b1;
        avm_address   = DCT_ADDR_SETQ;
        avm_writedata = qm_q;
        state_d       = SETSIZE;
      end

      SETSIZE: begin
        avm_write     = 1'b1;
        avm_address   = DCT_ADDR_START;
        avm_writedata = NBITS'(size_q);
        state_d       = LOAD;
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          avm_write     = 1'b1;
          avm_address   = DCT_ADDR_DATA;
          avm_writedata = in_data;
          count_d       = count_q + 9'd1;
          if (count_q + 9'd1 == size_q) begin
            k_d     = '0;
            state_d = READ;
          end
        end
      end

      READ: begin
        if (out_valid_q) begin
          // One-entry output buffer: no new read until the held coefficient leaves.
          if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) state_d = FIN;
          end
        end else begin
          avm_read    = 1'b1;
          avm_address = k_q[7:0];
          if (avm_done) begin
            out_data_d  = avm_readdata;
            out_valid_d = 1'b1;
            out_last_d  = (k_q == size_q - 9'd1);
            k_d         = k_q + 9'd1;
          end
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dct_streamer.sv
// tb_dct_streamer: directed + randomized bench for dct_streamer.
// A stub peripheral returns coef[address] on reads; monitors log every bus
// write, every completed read and every output handshake, and the logs are
// compared against sequences built from the transform's rules.
module tb_dct_streamer;
  import dct_pkg::*;

  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [8:0]      cfg_size;
  logic [NB-1:0]   cfg_qm;
  logic            in_valid;
  logic            in_ready;
  logic [NB-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [NB-1:0]   out_data;
  logic            out_last;
  logic            busy;
  logic            err;
  logic [7:0]      avm_address;
  logic            avm_read;
  logic            avm_write;
  logic [NB-1:0]   avm_writedata;
  logic [NB-1:0]   avm_readdata;
  logic            avm_done;
  dct_strm_state_t dbg_state;

  logic [NB-1:0]   coef [0:255];

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_log[$];
  logic [31:0] rd_log[$];
  logic [31:0] out_log[$];
  int          overlap = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_out_q[$];

  dct_streamer #(.MAX_SIZE(256), .NBITS(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_size(cfg_size), .cfg_qm(cfg_qm),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_done(avm_done),
    .dbg_state(dbg_state)
  );

  // clock / peripheral stub
  always #5 clk = ~clk;
  assign avm_readdata = coef[avm_address];

  // monitors sample at the falling edge, half a cycle away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (avm_write) wr_log.push_back({8'h0, avm_address, avm_writedata});
      if (avm_read && avm_done) rd_log.push_back(32'(avm_address));
      if (out_valid && out_ready) out_log.push_back({15'h0, out_last, out_data});
      if (avm_read && avm_write) overlap++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    out_log.delete();
    overlap = 0;
  endtask

  // One complete transform with optional gaps, bus stall, output backpressure,
  // random out_ready, and a start pulse while busy.
  task automatic run_xfer(input int n, input logic [NB-1:0] qm, input bit fixed,
                          input bit gaps, input int stall_addr, input int stall_len,
                          input int bp_idx, input int bp_len, input bit rnd_rdy,
                          input bit swb);
    logic [NB-1:0] samp[$];
    int si, cyc, stall_cnt, bp_cnt;
    bit stall_act, bp_act;

    clear_logs();
    exp_q.delete();
    exp_out_q.delete();
    for (int i = 0; i < 256; i++) coef[i] = NB'($urandom);
    for (int i = 0; i < n; i++) samp.push_back(fixed ? NB'(i + 1) : NB'($urandom));

    exp_q.push_back({8'h0, 8'd2, qm});
    exp_q.push_back({8'h0, 8'd0, NB'(n)});
    for (int i = 0; i < n; i++) exp_q.push_back({8'h0, 8'd1, samp[i]});
    for (int i = 0; i < n; i++) exp_out_q.push_back({15'h0, (i == n - 1) ? 1'b1 : 1'b0, coef[i]});

    start = 1'b1; cfg_size = 9'(n); cfg_qm = qm;
    step();
    start = 1'b0;
    chk("start_err_clear", err, 0);
    chk("start_busy", busy, 1);

    si = 0; cyc = 0; stall_cnt = 0; bp_cnt = 0; stall_act = 0; bp_act = 0;
    while (!(out_log.size() == n && !busy) && cyc < 3000) begin
      in_valid = (si < n) && (gaps ? (cyc % 2 == 0) : 1'b1);
      in_data  = (si < n) ? samp[si] : '0;

      if (stall_act) begin
        chk("stall_read_held", avm_read, 1);
        chk("stall_addr_held", avm_address, stall_addr);
        avm_done = 1'b0;
        stall_cnt++;
        if (stall_cnt == stall_len) stall_act = 0;
      end else if (stall_len > 0 && stall_cnt == 0 && avm_read && avm_address == 8'(stall_addr)) begin
        avm_done = 1'b0;
        stall_cnt = 1;
        stall_act = (stall_len > 1);
      end else begin
        avm_done = 1'b1;
      end

      if (bp_act) begin
        chk("bp_valid_held", out_valid, 1);
        chk("bp_data_held", out_data, coef[bp_idx]);
        chk("bp_no_read", avm_read, 0);
        out_ready = 1'b0;
        bp_cnt++;
        if (bp_cnt == bp_len) bp_act = 0;
      end else if (bp_len > 0 && bp_cnt == 0 && out_valid && out_log.size() == bp_idx) begin
        out_ready = 1'b0;
        bp_cnt = 1;
        bp_act = (bp_len > 1);
      end else begin
        out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      if (swb && si >= 2 && si < 4) begin
        start = 1'b1; cfg_size = 9'd3;
      end else begin
        start = 1'b0;
      end

      if (in_valid && in_ready) si++;
      step();
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; avm_done = 1'b1; out_ready = 1'b1;

    chk("run_timeout", (cyc < 3000) ? 1 : 0, 1);
    chk("wr_count", wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) chk("wr_item", wr_log[i], exp_q[i]);
    chk("rd_count", rd_log.size(), n);
    for (int i = 0; i < n && i < rd_log.size(); i++) chk("rd_addr", rd_log[i], i);
    chk("out_count", out_log.size(), exp_out_q.size());
    for (int i = 0; i < exp_out_q.size() && i < out_log.size(); i++) chk("out_item", out_log[i], exp_out_q[i]);
    chk("rw_overlap", overlap, 0);
    chk("end_err", err, 0);
    chk("end_state", dbg_state, IDLE);
    if (stall_len > 0) chk("stall_seen", stall_cnt, stall_len);
    if (bp_len > 0) chk("bp_seen", bp_cnt, bp_len);
  endtask

  initial begin
    int acc, cyc;

    // clock / reset
    reset = 1'b1; start = 1'b0; cfg_size = '0; cfg_qm = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; avm_done = 1'b1;
    for (int i = 0; i < 256; i++) coef[i] = '0;
    step(); step(); step();

    chk("rst_state", dbg_state, IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_write", avm_write, 0);
    chk("rst_avm_addr", avm_address, 0);
    chk("rst_avm_wdata", avm_writedata, 0);
    reset = 1'b0;
    step();

    // normal run: N=4, M=0, samples 1..4
    run_xfer(4, 16'd0, 1'b1, 1'b0, -1, 0, -1, 0, 1'b0, 1'b0);

    // size rejection
    clear_logs();
    start = 1'b1; cfg_size = 9'd1; cfg_qm = 16'd3;
    step();
    start = 1'b0;
    chk("rej1_err", err, 1);
    chk("rej1_busy", busy, 0);
    step();
    chk("rej1_busy_later", busy, 0);
    start = 1'b1; cfg_size = 9'd257;
    step();
    start = 1'b0;
    chk("rej257_err", err, 1);
    chk("rej257_busy", busy, 0);
    step();
    chk("rej257_busy_later", busy, 0);
    start = 1'b1; cfg_size = 9'd0;
    step();
    start = 1'b0;
    chk("rej0_err", err, 1);
    step();
    chk("rej_no_write", wr_log.size(), 0);
    chk("rej_state", dbg_state, IDLE);

    // bus stall on address 2 (also clears the sticky err)
    run_xfer(6, 16'd5, 1'b0, 1'b0, 2, 5, -1, 0, 1'b0, 1'b0);

    // output backpressure at k=1
    run_xfer(5, 16'd7, 1'b0, 1'b0, -1, 0, 1, 3, 1'b0, 1'b0);

    // reset after 2 of 8 samples
    clear_logs();
    start = 1'b1; cfg_size = 9'd8; cfg_qm = 16'd1;
    step();
    start = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 2 && cyc < 50) begin
      in_valid = 1'b1; in_data = NB'($urandom);
      if (in_ready) acc++;
      step();
      cyc++;
    end
    chk("mid_reset_reach", acc, 2);
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("mid_reset_state", dbg_state, IDLE);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_in_ready", in_ready, 0);
    chk("mid_reset_write", avm_write, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_reset_idle", busy, 0);
    run_xfer(8, 16'd2, 1'b0, 1'b0, -1, 0, -1, 0, 1'b0, 1'b0);

    // upstream gaps with start pulsed while busy
    run_xfer(6, 16'd4, 1'b0, 1'b1, -1, 0, -1, 0, 1'b0, 1'b1);
    step();
    chk("swb_ignored", busy, 0);

    // boundary lengths with random output readiness
    run_xfer(2, 16'($urandom), 1'b0, 1'b0, -1, 0, -1, 0, 1'b1, 1'b0);
    run_xfer(256, 16'($urandom), 1'b0, 1'b1, 200, 3, -1, 0, 1'b1, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
